// File: rtl/bus_sel_reg.sv
// Registered source selector driving a tristate bus through an
// IDLE/ARM/DRIVE/RELEASE handshake, with optional auto-scan of sources.
module bus_sel_reg #(
  parameter int WIDTH = 4,
  parameter int NSRC  = 2,
  parameter int SELW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH*NSRC-1:0] din,
  input  logic [SELW-1:0]       sel,
  input  logic                  sel_load,
  input  logic                  enb_n,
  input  logic                  scan,
  output logic [WIDTH-1:0]      dout,
  output logic                  driving,
  output logic [SELW-1:0]       cur_sel,
  output logic                  sel_err
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DRIVE,
    RELEASE
  } state_t;

  localparam logic [SELW:0]   NSRC_V = (SELW+1)'(NSRC);
  localparam logic [SELW-1:0] LAST   = SELW'(NSRC - 1);

  state_t          state;
  logic [SELW-1:0] sel_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] slice;
  logic            drive_q;
  logic            sel_ok;

  assign sel_ok = {1'b0, sel} < NSRC_V;

  always_comb begin
    slice = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_q == SELW'(k)) slice = din[k*WIDTH +: WIDTH];
    end
  end

  // drive_q tracks state==DRIVE so the bus enable comes straight off a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      sel_err <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      data_q  <= slice;
      sel_err <= sel_load && !sel_ok;
      if (sel_load && sel_ok) begin
        sel_q <= sel;
      end else if (scan && state == DRIVE) begin
        sel_q <= (sel_q == LAST) ? '0 : sel_q + SELW'(1);
      end
      unique case (state)
        IDLE: begin
          if (!enb_n) state <= ARM;
        end
        ARM: begin
          if (!enb_n) begin
            state   <= DRIVE;
            drive_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (enb_n) begin
            state   <= RELEASE;
            drive_q <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dout    = drive_q ? data_q : 'z;
  assign driving = drive_q;
  assign cur_sel = sel_q;

endmodule

// File: tb/tb_bus_sel_reg.sv
// Randomized scoreboard bench for bus_sel_reg (3 sources of 4 bits).
module tb_bus_sel_reg;

  localparam int W = 4;
  localparam int N = 3;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W*N-1:0] din;
  logic [S-1:0] sel;
  logic         sel_load;
  logic         enb_n;
  logic         scan;
  wire  [W-1:0] dout;
  logic         driving;
  logic [S-1:0] cur_sel;
  logic         sel_err;

  bus_sel_reg #(.WIDTH(W), .NSRC(N), .SELW(S)) dut (
    .clk(clk), .reset(reset), .din(din), .sel(sel),
    .sel_load(sel_load), .enb_n(enb_n), .scan(scan),
    .dout(dout), .driving(driving), .cur_sel(cur_sel),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int drv;
    int data;
    int sel;
    int err;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  bit done = 0;

  // reference: phase 0=idle 1=arm 2=drive 3=release
  int m_ph = 0;
  int m_sel = 0;
  int m_data = 0;
  int m_err = 0;

  task automatic model_edge();
    int nph;
    if (reset) begin
      m_ph = 0; m_sel = 0; m_data = 0; m_err = 0;
    end else begin
      m_data = (din >> (m_sel * W)) % (1 << W);
      m_err = (sel_load && int'(sel) >= N) ? 1 : 0;
      case (m_ph)
        0: nph = enb_n ? 0 : 1;
        1: nph = enb_n ? 0 : 2;
        2: nph = enb_n ? 3 : 2;
        default: nph = 0;
      endcase
      if (sel_load && int'(sel) < N) m_sel = int'(sel);
      else if (scan && m_ph == 2) m_sel = (m_sel + 1) % N;
      m_ph = nph;
    end
    q.push_back('{drv: (m_ph == 2) ? 1 : 0, data: m_data,
                  sel: m_sel, err: m_err});
  endtask

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, act, req);
    end
  endtask

  // monitor: pops one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("driving", int'(driving), e.drv);
        check("cur_sel", int'(cur_sel), e.sel);
        check("sel_err", int'(sel_err), e.err);
        if (e.drv == 1) check("dout", int'(dout), e.data);
      end
    end
  end

  task automatic step(logic r, logic sl, logic [S-1:0] s,
                      logic en, logic sc);
    @(negedge clk);
    reset = r; sel_load = sl; sel = s; enb_n = en; scan = sc;
    din = (W*N)'($urandom);
    model_edge();
  endtask

  initial begin
    reset = 1; sel_load = 0; sel = 0; enb_n = 1; scan = 0; din = '0;
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    // basic drive, release, immediate re-request
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    // scan wrap in DRIVE
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    // priority of load over scan
    step(0, 1, 2'd2, 0, 1);
    step(0, 0, 0, 0, 0);
    // out-of-range load
    step(0, 1, 2'd3, 0, 0);
    step(0, 0, 0, 0, 0);
    // reset mid-drive
    step(0, 1, 2'd2, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0),
           S'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 1) == 1));
    end
    step(0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
